// File: rtl/climate_ctrl.sv
// climate_ctrl: hysteresis-based incubator climate controller.
// Drives a heater, a cooler and a three-stage cooler-rate setting (CRS) from a
// qualified temperature sample, with a minimum-dwell anti-chatter counter.
// Optional feature: define CLIMATE_CTRL_ALARM_EN to build the latched
// over-temperature alarm; otherwise alarm is tied low and alarm_clr is ignored.
module climate_ctrl #(
    parameter int TW         = 8,
    parameter int CW         = 8,
    parameter int T_HEAT_ON  = 15,
    parameter int T_HEAT_OFF = 30,
    parameter int T_C1_ON    = 35,
    parameter int T_C1_OFF   = 25,
    parameter int T_C2_ON    = 40,
    parameter int T_C2_OFF   = 35,
    parameter int T_C3_ON    = 45,
    parameter int T_C3_OFF   = 40,
    parameter int CRS1       = 4,
    parameter int CRS2       = 6,
    parameter int CRS3       = 8,
    parameter int MIN_DWELL  = 0,
    parameter int T_ALARM    = 50,
    parameter int ALARM_CNT  = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [TW-1:0] T,
    input  logic          t_vld,
    input  logic          alarm_clr,
    output logic          Heater,
    output logic          Cooler,
    output logic [CW-1:0] CRS,
    output logic [2:0]    state,
    output logic          alarm
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HEAT  = 3'd1,
        COOL1 = 3'd2,
        COOL2 = 3'd3,
        COOL3 = 3'd4
    } state_t;

    // Thresholds resized once to the sample width so every compare is unsigned.
    localparam logic [TW-1:0] TH_HEAT_ON  = TW'(T_HEAT_ON);
    localparam logic [TW-1:0] TH_HEAT_OFF = TW'(T_HEAT_OFF);
    localparam logic [TW-1:0] TH_C1_ON    = TW'(T_C1_ON);
    localparam logic [TW-1:0] TH_C1_OFF   = TW'(T_C1_OFF);
    localparam logic [TW-1:0] TH_C2_ON    = TW'(T_C2_ON);
    localparam logic [TW-1:0] TH_C2_OFF   = TW'(T_C2_OFF);
    localparam logic [TW-1:0] TH_C3_ON    = TW'(T_C3_ON);
    localparam logic [TW-1:0] TH_C3_OFF   = TW'(T_C3_OFF);

    localparam int            DW        = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;
    localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);

    state_t        state_q;
    state_t        cand;
    state_t        nxt;
    logic          go;
    logic          state_ok;
    logic [DW-1:0] dwell;
    logic          dwell_ok;

    assign state    = state_q;
    assign dwell_ok = (dwell == DWELL_MAX);
    assign state_ok = (state_q <= COOL3);

    // Candidate next state from the hysteresis thresholds, ignoring qualifiers.
    always_comb begin
        // NOTE: default first so every path assigns cand and no latch is inferred.
        cand = state_q;
        unique case (state_q)
            IDLE: begin
                if (T < TH_HEAT_ON)    cand = HEAT;
                else if (T > TH_C1_ON) cand = COOL1;
            end
            HEAT:  if (T > TH_HEAT_OFF) cand = IDLE;
            COOL1: begin
                if (T > TH_C2_ON)       cand = COOL2;
                else if (T < TH_C1_OFF) cand = IDLE;
            end
            COOL2: begin
                if (T > TH_C3_ON)       cand = COOL3;
                else if (T < TH_C2_OFF) cand = COOL1;
            end
            COOL3: if (T < TH_C3_OFF)   cand = COOL2;
            default: cand = IDLE;
        endcase
    end

    // Qualify the move: a valid sample plus dwell, or recovery from a bad encoding.
    always_comb begin
        go  = !state_ok || (t_vld && dwell_ok && (cand != state_q));
        nxt = go ? cand : state_q;
    end

    // State, dwell counter and outputs registered together from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= IDLE;
            dwell   <= DWELL_MAX;
            Heater  <= 1'b0;
            Cooler  <= 1'b0;
            CRS     <= '0;
        end else begin
            state_q <= nxt;
            if (go)             dwell <= '0;
            else if (!dwell_ok) dwell <= dwell + 1'b1;
            Heater <= 1'b0;
            Cooler <= 1'b0;
            CRS    <= '0;
            unique case (nxt)
                HEAT:  Heater <= 1'b1;
                COOL1: begin Cooler <= 1'b1; CRS <= CW'(CRS1); end
                COOL2: begin Cooler <= 1'b1; CRS <= CW'(CRS2); end
                COOL3: begin Cooler <= 1'b1; CRS <= CW'(CRS3); end
                default: ;
            endcase
        end
    end

`ifdef CLIMATE_CTRL_ALARM_EN
    localparam int            AW        = (ALARM_CNT > 0) ? $clog2(ALARM_CNT + 1) : 1;
    localparam logic [AW-1:0] ACNT_MAX  = AW'(ALARM_CNT);
    localparam logic [TW-1:0] TH_ALARM  = TW'(T_ALARM);

    logic [AW-1:0] acnt;
    logic [AW-1:0] acnt_nxt;
    logic          hot;

    // Consecutive over-temperature sample count, saturating at ALARM_CNT.
    always_comb begin
        hot      = (T > TH_ALARM);
        acnt_nxt = acnt;
        if (t_vld) begin
            if (!hot)                  acnt_nxt = '0;
            else if (acnt != ACNT_MAX) acnt_nxt = acnt + 1'b1;
        end
    end

    // Latched alarm: a qualifying sample that reaches the count beats a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acnt  <= '0;
            alarm <= 1'b0;
        end else begin
            acnt <= acnt_nxt;
            if (t_vld && hot && (acnt_nxt == ACNT_MAX)) alarm <= 1'b1;
            else if (alarm_clr)                         alarm <= 1'b0;
        end
    end
`else
    logic unused_alarm_cfg;
    assign unused_alarm_cfg = alarm_clr ^ ((T_ALARM + ALARM_CNT) != 0);
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_climate_ctrl.sv
// Bench for climate_ctrl: two instances (no dwell, dwell of 3) share stimulus;
// a threshold-rule model is compared every cycle, plus directed literal checks.
module tb_climate_ctrl;

`ifdef CLIMATE_CTRL_ALARM_EN
    localparam bit AEN = 1'b1;
`else
    localparam bit AEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] T;
    logic       t_vld;
    logic       alarm_clr;

    logic       h0, c0, al0, h1, c1, al1;
    logic [7:0] crs0, crs1;
    logic [2:0] st0, st1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    climate_ctrl dut0 (
        .clk(clk), .reset(reset), .T(T), .t_vld(t_vld), .alarm_clr(alarm_clr),
        .Heater(h0), .Cooler(c0), .CRS(crs0), .state(st0), .alarm(al0)
    );

    climate_ctrl #(.MIN_DWELL(3)) dut1 (
        .clk(clk), .reset(reset), .T(T), .t_vld(t_vld), .alarm_clr(alarm_clr),
        .Heater(h1), .Cooler(c1), .CRS(crs1), .state(st1), .alarm(al1)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Temperature rules stated directly on state numbers 0..4.
    function automatic int rule_next(input int s, input int t);
        case (s)
            0:       return (t < 15) ? 1 : (t > 35) ? 2 : 0;
            1:       return (t > 30) ? 0 : 1;
            2:       return (t > 40) ? 3 : (t < 25) ? 0 : 2;
            3:       return (t > 45) ? 4 : (t < 35) ? 2 : 3;
            4:       return (t < 40) ? 3 : 4;
            default: return 0;
        endcase
    endfunction

    function automatic int rate_of(input int s);
        case (s)
            2:       return 4;
            3:       return 6;
            4:       return 8;
            default: return 0;
        endcase
    endfunction

    int m_state [2];
    int m_since [2];   // cycles spent in the current state
    int m_acnt;
    bit m_alarm;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_state[i] <= 0;
                m_since[i] <= 1000;
            end
            m_acnt  <= 0;
            m_alarm <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                int need;
                int nx;
                need = (i == 0) ? 0 : 3;
                nx   = rule_next(m_state[i], int'(T));
                if (t_vld && m_since[i] >= need && nx != m_state[i]) begin
                    m_state[i] <= nx;
                    m_since[i] <= 0;
                end else begin
                    m_since[i] <= (m_since[i] < 1000) ? m_since[i] + 1 : 1000;
                end
            end
            if (AEN) begin
                if (t_vld && T > 8'd50) begin
                    m_acnt <= (m_acnt + 1 > 3) ? 3 : m_acnt + 1;
                    if (m_acnt + 1 >= 3) m_alarm <= 1'b1;
                    else if (alarm_clr)  m_alarm <= 1'b0;
                end else begin
                    if (t_vld)     m_acnt  <= 0;
                    if (alarm_clr) m_alarm <= 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison on the falling edge.
    always @(negedge clk) begin
        check("st0",  int'(st0),  m_state[0]);
        check("h0",   int'(h0),   int'(m_state[0] == 1));
        check("c0",   int'(c0),   int'(m_state[0] >= 2));
        check("crs0", int'(crs0), rate_of(m_state[0]));
        check("al0",  int'(al0),  int'(m_alarm));
        check("st1",  int'(st1),  m_state[1]);
        check("h1",   int'(h1),   int'(m_state[1] == 1));
        check("c1",   int'(c1),   int'(m_state[1] >= 2));
        check("crs1", int'(crs1), rate_of(m_state[1]));
        check("al1",  int'(al1),  int'(m_alarm));
        check("hc_excl0", int'(h0 & c0), 0);
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int t, input bit v, input bit clr);
        T         = 8'(t);
        t_vld     = v;
        alarm_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; T = 8'd0; t_vld = 1'b0; alarm_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", int'(st0), 0);
        check("rst_heat",  int'(h0),  0);
        check("rst_crs",   int'(crs0), 0);
        reset = 1'b1;

        // Heat entry and exit; dwell instance must hold HEAT until edge k+4.
        step(10, 1, 0);
        check("heat_st",  int'(st0), 1);
        check("heat_h",   int'(h0),  1);
        check("heat_st1", int'(st1), 1);
        step(31, 1, 0);
        check("idle_st",  int'(st0), 0);
        check("idle_h",   int'(h0),  0);
        check("dw_k1",    int'(st1), 1);
        step(31, 1, 0);
        check("dw_k2",    int'(st1), 1);
        step(31, 1, 0);
        check("dw_k3",    int'(st1), 1);
        step(31, 1, 0);
        check("dw_k4",    int'(st1), 0);
        check("dw_k4_h",  int'(h1),  0);

        // Cooling ramp up and down.
        step(36, 1, 0); check("c1_st", int'(st0), 2); check("c1_crs", int'(crs0), 4);
        step(41, 1, 0); check("c2_st", int'(st0), 3); check("c2_crs", int'(crs0), 6);
        step(46, 1, 0); check("c3_st", int'(st0), 4); check("c3_crs", int'(crs0), 8);
        check("c3_cool", int'(c0), 1);
        step(39, 1, 0); check("d2_st", int'(st0), 3); check("d2_crs", int'(crs0), 6);
        step(34, 1, 0); check("d1_st", int'(st0), 2); check("d1_crs", int'(crs0), 4);
        step(24, 1, 0); check("d0_st", int'(st0), 0); check("d0_crs", int'(crs0), 0);

        // Invalid samples are ignored.
        for (int i = 0; i < 5; i++) begin
            step(10, 0, 0);
            check("nv_st", int'(st0), 0);
            check("nv_h",  int'(h0),  0);
        end

        // Alarm behaviour (expected low throughout when the feature is absent).
        step(51, 1, 0); check("al_s1", int'(al0), 0);
        step(51, 1, 0); check("al_s2", int'(al0), 0);
        step(51, 1, 0); check("al_s3", int'(al0), int'(AEN));
        step(30, 1, 1); check("al_clr", int'(al0), 0);
        step(51, 1, 0);
        step(51, 1, 0); check("al_i2", int'(al0), 0);
        step(50, 1, 0); check("al_i50", int'(al0), 0);
        step(51, 1, 0); check("al_r1", int'(al0), 0);
        step(51, 1, 0); check("al_r2", int'(al0), 0);
        step(51, 1, 0); check("al_r3", int'(al0), int'(AEN));
        step(51, 1, 1); check("al_setwins", int'(al0), int'(AEN));
        check("pre_rst_st", int'(st0), 4);

        // Asynchronous reset between edges, while in COOL3 with alarm set.
        #2;
        reset = 1'b0;
        #1;
        check("arst_st",  int'(st0),  0);
        check("arst_c",   int'(c0),   0);
        check("arst_crs", int'(crs0), 0);
        check("arst_al",  int'(al0),  0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(10, 1, 0);
        check("post_rst", int'(st0), 1);
        step(20, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
